uart_rx_deserializer: RTL
=========================

// Module: uart_rx_deserializer
// PURPOSE
//   UART receiver: the downstream peer of the UART transmitter on the serial link.
//   Recovers 8N1 frames (start, 8 data bits LSB first, 1 stop) from the async line rx.
//   Presents each byte on dout with a one-cycle done_rx strobe, or a frame_err strobe.
//   Runs entirely on the system clock; bit timing comes from an internal down-counter.
// PARAMETERS
//   clk_freq  1E6   system clock frequency, Hz
//   baud      9600  line bit rate, bits/s
//   Derived: CPB = clk_freq/baud (integer division). CPB >= 4 is required; elaboration error otherwise.
// PORTS
//   clk        in   1  system clock; all logic on posedge
//   rst_n      in   1  synchronous, active-low reset
//   rx         in   1  async serial line, idle high
//   dout       out  8  last good byte; holds until the next good frame
//   done_rx    out  1  1-cycle pulse: dout updated this cycle
//   frame_err  out  1  1-cycle pulse: stop bit sampled low; dout unchanged
//   busy       out  1  high in any state other than IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state=IDLE, dout=0, done_rx=0, frame_err=0, busy=0.
//     Shift register, counters and both sync flops are set to 1 (idle line).
//     Reset applies mid-frame: the partial byte is discarded and no strobe is issued.
//   Input sync: rx passes through two flops to give rx_s. All decisions use rx_s only.
//   Counters: cnt has width clog2(CPB). bit_idx is 3 bits. cnt clears on every state change.
//   FSM
//     IDLE:  rx_s==0 -> START, cnt=0.
//     START: cnt counts up. At cnt==CPB/2-1, check rx_s:
//              rx_s==0 -> DATA, cnt=0, bit_idx=0.
//              rx_s==1 -> IDLE (glitch rejected, no strobe).
//     DATA:  at cnt==CPB-1, shift[bit_idx]<=rx_s, cnt=0, bit_idx++.
//              After bit_idx==7 is sampled -> STOP.
//     STOP:  at cnt==CPB-1 (mid stop bit), check rx_s:
//              rx_s==1 -> dout<=shift, done_rx=1 for that cycle only, -> IDLE.
//              rx_s==0 -> frame_err=1 for that cycle only, -> BREAK.
//     BREAK: wait for rx_s==1 -> IDLE. A held-low line (break) produces one frame_err only.
//   Stop handling: no wait through the second half of the stop bit.
//     Returning to IDLE at mid-stop lets back-to-back frames resync on the next start edge.
//   Latency, line fall to done_rx: 2 (sync) + 1 (IDLE detect) + CPB/2 + 9*CPB cycles (+/-1).
//   done_rx and frame_err are never high in the same cycle.
//   No overrun flag: the consumer must take dout before the next done_rx.
//   Line tolerance: correct reception with up to +/-3% baud mismatch at CPB>=16.
// TESTING  (bench uses clk_freq=16, baud=1 -> CPB=16 unless stated)
//   1. Send 0xA5 as 8N1 at exact rate.
//      -> one done_rx pulse, dout=8'hA5, frame_err never high.
//   2. Back-to-back 0x00, 0xFF, 0x3C with no idle gap.
//      -> three done_rx pulses, dout 00, FF, 3C in order.
//   3. rx low for 5 cycles, then high (glitch).
//      -> returns to IDLE, busy drops, no done_rx/frame_err.
//   4. Send 0x55 with stop bit driven low, line then held low 40 cycles, then released.
//      -> exactly one frame_err pulse, dout unchanged, rx accepted after line goes high.
//   5. rst_n=0 for 1 cycle during data bit 4 of 0x81, then a clean 0x81.
//      -> no strobe for the first frame, done_rx with dout=8'h81 for the second.
//   6. Default params (CPB=104): send 0xC3 at 9300 baud and at 9900 baud.
//      -> dout=8'hC3 both times, no frame_err.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver: recovers bytes from an async idle-high serial line.
// Ports: clk, rst_n (sync, active-low), rx (line), dout (last good byte),
//   done_rx (1-cycle byte strobe), frame_err (1-cycle bad-stop strobe),
//   busy (receiver not idle).
module uart_rx_deserializer #(
    parameter int clk_freq = 1_000_000,
    parameter int baud     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       done_rx,
    output logic       frame_err,
    output logic       busy
);

    localparam int CPB = clk_freq / baud;
    localparam int CW  = $clog2(CPB);

    localparam logic [CW-1:0] HALF = CW'(CPB / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CPB - 1);

    if (CPB < 4) begin : g_cpb_chk
        $error("uart_rx_deserializer: clk_freq/baud must be >= 4");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_q1;
    logic          rx_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '1;
            bit_idx   <= '1;
            shift     <= '1;
            rx_q1     <= 1'b1;
            rx_s      <= 1'b1;
            dout      <= '0;
            done_rx   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_q1     <= rx;
            rx_s      <= rx_q1;
            done_rx   <= 1'b0;
            frame_err <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                // Confirm the start bit at its midpoint; a short low
                // pulse is treated as noise.
                START: begin
                    if (cnt == HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == LAST) begin
                        shift[bit_idx] <= rx_s;
                        cnt            <= '0;
                        bit_idx        <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Decide at mid stop bit so the next start edge can be
                // caught without waiting out the rest of the stop bit.
                STOP: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            dout    <= shift;
                            done_rx <= 1'b1;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Held-low line: stay here until it returns high so a
                // break reports only one frame error.
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
